// File: rtl/tick_sched_pkg.sv
// Shared FSM encoding and default widths for the tick scheduler.
package tick_sched_pkg;

   localparam int CNT_W_DEF  = 27;
   localparam int STEP_W_DEF = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tick_sched_cnt.sv
// Half-period counter: counts 0..H-1 and flags wrap combinationally at H-1 (H=0 behaves as 1).
// No backpressure; clear holds the count at zero.
module tick_sched_cnt
   import tick_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [CNT_W-1:0] half,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last;

   always_comb begin
      last = '0;
      if (half != '0)
         last = half - CNT_W'(1);
   end

   assign wrap = (cnt == last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear || wrap)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/tick_sched.sv
// Divided clock / tick generator; first tick H cycles after start, then every 2H; outputs registered.
// Config handshake stalls (cfg_ready low) while a run-time update waits for the next falling edge.
module tick_sched
   import tick_sched_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int STEP_W = STEP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CNT_W-1:0]  cfg_half,
   input  logic [STEP_W-1:0] cfg_steps,
   input  logic              start,
   input  logic              stop,
   output logic              clk_out,
   output logic              tick,
   output logic              done,
   output logic              busy,
   output logic [STEP_W-1:0] step_idx
);

   state_t            state;
   logic [CNT_W-1:0]  act_half;
   logic [CNT_W-1:0]  sh_half;
   logic [STEP_W-1:0] act_steps;
   logic [STEP_W-1:0] sh_steps;
   logic              sh_full;
   logic              wrap;
   logic              cfg_acc;
   logic              rise;
   logic              fall;
   logic              finish;
   logic [STEP_W-1:0] eff_steps;

   tick_sched_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state != ST_RUN),
      .half  (act_half),
      .wrap  (wrap)
   );

   assign cfg_ready = !sh_full;
   assign cfg_acc   = cfg_valid && !sh_full;
   assign rise      = (state == ST_RUN) && wrap && !clk_out;
   assign fall      = (state == ST_RUN) && wrap && clk_out;

   // A pending step count is judged at the same falling edge that installs it.
   assign eff_steps = sh_full ? sh_steps : act_steps;
   assign finish    = fall && (eff_steps != '0) && (step_idx >= eff_steps);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         clk_out   <= 1'b0;
         tick      <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         step_idx  <= '0;
         sh_full   <= 1'b0;
         sh_half   <= '0;
         sh_steps  <= '0;
         act_half  <= CNT_W'(1);
         act_steps <= '0;
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               busy <= 1'b0;
               if (cfg_acc) begin
                  act_half  <= cfg_half;
                  act_steps <= cfg_steps;
               end
               if (start && !stop) begin
                  state    <= ST_RUN;
                  busy     <= 1'b1;
                  step_idx <= '0;
                  clk_out  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state   <= ST_IDLE;
                  clk_out <= 1'b0;
                  busy    <= 1'b0;
                  sh_full <= 1'b0;
               end else begin
                  if (cfg_acc) begin
                     sh_full  <= 1'b1;
                     sh_half  <= cfg_half;
                     sh_steps <= cfg_steps;
                  end
                  if (rise) begin
                     clk_out <= 1'b1;
                     tick    <= 1'b1;
                     if (step_idx != {STEP_W{1'b1}})
                        step_idx <= step_idx + STEP_W'(1);
                  end
                  if (fall) begin
                     clk_out <= 1'b0;
                     if (sh_full) begin
                        act_half  <= sh_half;
                        act_steps <= sh_steps;
                        sh_full   <= 1'b0;
                     end
                     // busy stays high through the done cycle and drops from IDLE next cycle.
                     if (finish) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched: expected tick/done events are queued with their cycle numbers.
module tb_tick_sched;

   localparam int CNT_W  = 27;
   localparam int STEP_W = 8;
   localparam int EV_TICK = 0;
   localparam int EV_DONE = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [CNT_W-1:0]  cfg_half = '0;
   logic [STEP_W-1:0] cfg_steps = '0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              clk_out;
   logic              tick;
   logic              done;
   logic              busy;
   logic [STEP_W-1:0] step_idx;

   tick_sched #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_half  (cfg_half),
      .cfg_steps (cfg_steps),
      .start     (start),
      .stop      (stop),
      .clk_out   (clk_out),
      .tick      (tick),
      .done      (done),
      .busy      (busy),
      .step_idx  (step_idx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int at;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   function automatic void expect_ev(int kind, int at);
      ev_t e;
      e.kind = kind;
      e.at   = at;
      exp_q.push_back(e);
   endfunction

   task automatic chk(string name, longint act, longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic got_ev(int kind);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.at != cyc) begin
            errors++;
            $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     kind, cyc, e.kind, e.at);
         end
      end
   endtask

   // Monitor: any tick or done pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (tick) got_ev(EV_TICK);
         if (done) got_ev(EV_DONE);
      end
   end

   task automatic cyc_wait(int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic set_cfg(int h, int s);
      cfg_valid = 1'b1;
      cfg_half  = CNT_W'(h);
      cfg_steps = STEP_W'(s);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic do_start(output int t0);
      start = 1'b1;
      t0    = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_clk_out"}, clk_out, 0);
      chk({tag, "_tick"}, tick, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_step_idx"}, step_idx, 0);
      chk({tag, "_cfg_ready"}, cfg_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;

      @(negedge clk);
      #1 chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // H=3, S=2
      set_cfg(3, 2);
      do_start(t0);
      expect_ev(EV_TICK, t0 + 3);
      expect_ev(EV_TICK, t0 + 9);
      expect_ev(EV_DONE, t0 + 12);
      cyc_wait(t0 + 12);
      chk("h3_busy_at_done", busy, 1);
      chk("h3_step_idx", step_idx, 2);
      cyc_wait(t0 + 13);
      chk("h3_busy_after", busy, 0);
      chk("h3_step_idx_hold", step_idx, 2);

      // cfg_half=0 behaves as H=1, S=1
      set_cfg(0, 1);
      do_start(t0);
      expect_ev(EV_TICK, t0 + 1);
      expect_ev(EV_DONE, t0 + 2);
      cyc_wait(t0 + 1);
      chk("h0_clk_out_high", clk_out, 1);
      cyc_wait(t0 + 3);
      chk("h0_busy_after", busy, 0);

      // H=1 free-running, stop during cycle 20
      set_cfg(1, 0);
      do_start(t0);
      for (int k = 0; k < 10; k++) expect_ev(EV_TICK, t0 + 1 + 2 * k);
      cyc_wait(t0 + 5);
      chk("h1_clk_out_odd", clk_out, 1);
      cyc_wait(t0 + 6);
      chk("h1_clk_out_even", clk_out, 0);
      cyc_wait(t0 + 20);
      chk("h1_busy_before_stop", busy, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("h1_stop_clk_out", clk_out, 0);
      chk("h1_stop_busy", busy, 0);
      chk("h1_stop_step_idx", step_idx, 10);

      // H=4 run, H=2 offered in high phase, applied at the falling edge
      set_cfg(4, 0);
      do_start(t0);
      expect_ev(EV_TICK, t0 + 4);
      expect_ev(EV_TICK, t0 + 10);
      expect_ev(EV_TICK, t0 + 14);
      cyc_wait(t0 + 5);
      cfg_valid = 1'b1;
      cfg_half  = CNT_W'(2);
      cfg_steps = '0;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("upd_cfg_ready_low", cfg_ready, 0);
      cyc_wait(t0 + 7);
      chk("upd_clk_out_high", clk_out, 1);
      chk("upd_cfg_ready_still_low", cfg_ready, 0);
      cyc_wait(t0 + 8);
      chk("upd_clk_out_fall", clk_out, 0);
      chk("upd_cfg_ready_back", cfg_ready, 1);
      cyc_wait(t0 + 9);
      chk("upd_clk_out_low2", clk_out, 0);
      cyc_wait(t0 + 10);
      chk("upd_clk_out_rise", clk_out, 1);
      cyc_wait(t0 + 15);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("upd_stop_busy", busy, 0);

      // Pending S=1 with step_idx=2 ends the run at the next falling edge
      set_cfg(2, 0);
      do_start(t0);
      expect_ev(EV_TICK, t0 + 2);
      expect_ev(EV_TICK, t0 + 6);
      expect_ev(EV_DONE, t0 + 8);
      cyc_wait(t0 + 6);
      cfg_valid = 1'b1;
      cfg_half  = CNT_W'(2);
      cfg_steps = STEP_W'(1);
      @(negedge clk);
      cfg_valid = 1'b0;
      cyc_wait(t0 + 8);
      chk("late_steps_idx", step_idx, 2);
      cyc_wait(t0 + 9);
      chk("late_steps_busy", busy, 0);
      chk("late_steps_cfg_ready", cfg_ready, 1);

      // start and stop together from IDLE: stop wins
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      repeat (6) @(negedge clk);
      chk("both_busy", busy, 0);
      chk("both_clk_out", clk_out, 0);
      chk("both_step_idx", step_idx, 2);

      // Asynchronous reset while clk_out is high
      set_cfg(3, 0);
      do_start(t0);
      expect_ev(EV_TICK, t0 + 3);
      cyc_wait(t0 + 4);
      chk("arst_pre_clk_out", clk_out, 1);
      chk("arst_pre_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("arst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("arst_no_resume_busy", busy, 0);
      chk("arst_no_resume_clk_out", clk_out, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 27: width of the half-period counter and divisor.
REQ-002 SHALL have parameter STEP_W, default 8: width of the step count and step index.
REQ-003 SHALL have port clk, input, 1: single system clock, 100 MHz reference.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port cfg_valid, input, 1: new configuration offered.
REQ-006 SHALL have port cfg_ready, output, 1: configuration can be accepted.
REQ-007 SHALL have port cfg_half, input, CNT_W: half-period in clk cycles; 0 is treated as 1.
REQ-008 SHALL have port cfg_steps, input, STEP_W: number of output periods per run; 0 means free-running.
REQ-009 SHALL have port start, input, 1: level-sampled run request.
REQ-010 SHALL have port stop, input, 1: level-sampled abort request.
REQ-011 SHALL have port clk_out, output, 1: registered divided square wave.
REQ-012 SHALL have port tick, output, 1: one-cycle pulse coincident with each 0->1 transition of clk_out.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a finite run completes.
REQ-014 SHALL have port busy, output, 1: high while in RUN.
REQ-015 SHALL have port step_idx, output, STEP_W: count of ticks issued in the current run.

Function
REQ-016 SHALL implement the FSM states IDLE and RUN; done is a registered pulse on the RUN->IDLE transition.
REQ-017 In IDLE, a sampled start with stop low SHALL clear the counter, set step_idx to 0 and enter RUN; tick SHALL NOT pulse on entry.
REQ-018 In RUN, the counter SHALL count 0..H-1, where H is the active half-period; at H-1 it SHALL wrap to 0 and toggle clk_out.
REQ-019 The first tick SHALL be asserted exactly H cycles after the cycle in which start is sampled; subsequent ticks SHALL be spaced 2H cycles apart.
REQ-020 Each tick SHALL increment step_idx; step_idx SHALL saturate at its maximum in free-running mode, and tick generation SHALL continue.
REQ-021 With S=cfg_steps nonzero, the S-th falling edge of clk_out SHALL pulse done in the same cycle and return the FSM to IDLE; busy SHALL be low from the next cycle.
REQ-022 A sampled stop in RUN SHALL return the FSM to IDLE next cycle, force clk_out low and suppress done.
REQ-023 When start and stop are sampled together, stop SHALL win; start while in RUN SHALL be ignored.
REQ-024 A configuration SHALL be accepted on cfg_valid&&cfg_ready; in IDLE, accepted values SHALL become active on the next cycle.
REQ-025 In RUN, an accepted configuration SHALL be held in a pending shadow register and applied only at the next clk_out falling edge, so that no partial period occurs.
REQ-026 cfg_ready SHALL be low while the shadow register is full and high otherwise.
REQ-027 A stop SHALL discard a pending configuration.
REQ-028 A newly applied cfg_steps value SHALL take effect against the current step_idx; if step_idx >= S at that point, the run SHALL end at the current falling edge.
REQ-029 All arithmetic SHALL be unsigned; compare-at-H-1 SHALL use an H of at least 1, and H=1 SHALL toggle clk_out every cycle.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously go to: FSM IDLE, counter 0, clk_out 0, tick 0, done 0, busy 0, step_idx 0, cfg_ready 1, shadow register empty, active half 1, active steps 0.
REQ-031 Reset asserted mid-run SHALL abort immediately with no done pulse; operation SHALL resume only on a fresh start after rst_n rises.

Structure
REQ-032 The FSM state encoding and the default widths (CNT_W, STEP_W) SHALL live in a shared package, tick_sched_pkg.
REQ-033 The half-period counter with its wrap detect SHALL be a sub-module, tick_sched_cnt, with inputs clk, rst_n, clear, half and output wrap.

Verification
REQ-034 H=3, S=2, start at cycle 0 -> tick at cycles 3 and 9; done at 12; busy low at 13; step_idx=2.
REQ-035 H=1, S=0, start -> clk_out toggles every cycle and tick every 2 cycles; stop at cycle 20 -> clk_out 0 and busy 0 at cycle 21, with no done.
REQ-036 Run H=4; offer H=2 mid high phase -> cfg_ready drops; current period finishes at 4/4; the next period is 2/2; cfg_ready returns high.
REQ-037 start and stop high in the same cycle from IDLE -> FSM remains IDLE, with no tick and no done.
REQ-038 rst_n pulsed low during RUN with clk_out high -> all outputs at reset values within the same cycle, with no done.
REQ-039 cfg_half=0, S=1 -> behaves as H=1: tick at cycle 1 and done at cycle 2.
